// File: rtl/inv_key_expansion.sv
// Purpose : AES-128 inverse key schedule. From the round-10 key it walks back
//           to the round-0 key and emits rounds 10..0 on a valid/ready port.
// Latency : rk_valid rises 1 cycle after start. After each handshake the next
//           key follows 4 cycles later (byte-serial S-box) or 1 cycle later when
//           INV_KEYEXP_PARALLEL_SBOX_EN is defined.
// Backpressure: rk and rk_round hold while rk_valid=1 and rk_ready=0.
// Ports   : clk, rst (async active-high); start/key_in load the round-10 key;
//           busy = not idle; rk_valid/rk_ready/rk/rk_round carry the round keys;
//           done pulses for one cycle after round 0 is accepted.
// Build option: INV_KEYEXP_PARALLEL_SBOX_EN selects four S-boxes and a 1-cycle SUB.
module inv_key_expansion (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk,
   output logic [3:0]   rk_round,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, EMIT, SUB} state_t;

   // AES S-box; entry x sits at bits [(255-x)*8 +: 8].
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] idx;
      idx = {~x, 3'b000};
      return SBOX_TBL[idx +: 8];
   endfunction

   // RCon used when stepping from round r back to round r-1.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   state_t        state_q, state_d;
   logic [127:0]  key_q, key_d;
   logic [3:0]    round_q, round_d;
   logic          done_q, done_d;

   logic [31:0]   n0, n1, n2, n3;
   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   rot, q, t;
   logic [127:0]  prev_key;

   assign n0 = key_q[31:0];
   assign n1 = key_q[63:32];
   assign n2 = key_q[95:64];
   assign n3 = key_q[127:96];

   assign w3  = n3 ^ n2;
   assign w2  = n2 ^ n1;
   assign w1  = n1 ^ n0;
   assign rot = {w3[7:0], w3[31:8]};

`ifdef INV_KEYEXP_PARALLEL_SBOX_EN
   assign q = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
`else
   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] sub_q, sub_d;     // Q bytes 0..2 gathered on earlier SUB cycles
   logic [7:0]  sbox_out;

   assign sbox_out = sbox(rot[{cnt_q, 3'b000} +: 8]);
   // Only meaningful on the cnt_q==3 cycle, when byte 3 is the live S-box result.
   assign q = {sbox_out, sub_q};
`endif

   assign t        = {q[31:8], q[7:0] ^ rcon(round_q)};
   assign w0       = n0 ^ t;
   assign prev_key = {w3, w2, w1, w0};

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      done_d  = 1'b0;
`ifndef INV_KEYEXP_PARALLEL_SBOX_EN
      cnt_d   = cnt_q;
      sub_d   = sub_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = key_in;
               round_d = 4'd10;
               state_d = EMIT;
`ifndef INV_KEYEXP_PARALLEL_SBOX_EN
               cnt_d   = 2'd0;
`endif
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (round_q == 4'd0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = SUB;
`ifndef INV_KEYEXP_PARALLEL_SBOX_EN
                  cnt_d   = 2'd0;
`endif
               end
            end
         end
         SUB: begin
`ifdef INV_KEYEXP_PARALLEL_SBOX_EN
            key_d   = prev_key;
            round_d = round_q - 4'd1;
            state_d = EMIT;
`else
            if (cnt_q == 2'd3) begin
               key_d   = prev_key;
               round_d = round_q - 4'd1;
               state_d = EMIT;
            end else begin
               cnt_d = cnt_q + 2'd1;
               case (cnt_q)
                  2'd0:    sub_d[7:0]   = sbox_out;
                  2'd1:    sub_d[15:8]  = sbox_out;
                  default: sub_d[23:16] = sbox_out;
               endcase
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

`ifndef INV_KEYEXP_PARALLEL_SBOX_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         sub_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         sub_q <= sub_d;
      end
   end
`endif

   assign busy     = (state_q != IDLE);
   assign rk_valid = (state_q == EMIT);
   assign rk       = key_q;
   assign rk_round = round_q;
   assign done     = done_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
module tb_inv_key_expansion;

   logic         clk = 1'b0;
   logic         rst, start, rk_ready;
   logic [127:0] key_in;
   logic         busy, rk_valid, done;
   logic [127:0] rk;
   logic [3:0]   rk_round;

   always #5 clk = ~clk;

   inv_key_expansion dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk       (rk),
      .rk_round (rk_round),
      .done     (done)
   );

`ifdef INV_KEYEXP_PARALLEL_SBOX_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 4;
`endif

   int           n_checks = 0;
   int           n_pass   = 0;
   int           cyc_cnt  = 0;
   logic [7:0]   sbox_ref [256];
   logic [7:0]   rcon_ref [10];
   logic [127:0] ks [11];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc_cnt++;
   endtask

   // ---- reference model: GF(2^8) arithmetic and forward key schedule ----
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v};
      return d[15-n -: 8];
   endfunction

   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      rcon_ref[0] = 8'h01;
      for (int i = 1; i < 10; i++) rcon_ref[i] = xtime(rcon_ref[i-1]);
   endtask

   // Forward step k_r -> k_{r+1}; byte j of a word is bits [8j+7:8j].
   function automatic logic [127:0] fwd(input logic [127:0] k, input int r);
      logic [31:0] w [4];
      logic [31:0] n [4];
      logic [31:0] tw;
      for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
      for (int j = 0; j < 4; j++) tw[8*j +: 8] = sbox_ref[w[3][8*((j+1)%4) +: 8]];
      tw[7:0] = tw[7:0] ^ rcon_ref[r];
      n[0] = w[0] ^ tw;
      for (int i = 1; i < 4; i++) n[i] = w[i] ^ n[i-1];
      return {n[3], n[2], n[1], n[0]};
   endfunction

   // One full inverse run from key k0's round-10 key.
   //   rand_bp : random rk_ready stalls     poke   : start pulse during SUB
   //   rst_at  : round at which to reset    hold_at: round held for 7 cycles
   task automatic run_seq(input logic [127:0] k0, input bit rand_bp, input bit poke,
                          input int rst_at, input int hold_at);
      int cyc, t_start;
      ks[0] = k0;
      for (int r = 0; r < 10; r++) ks[r+1] = fwd(ks[r], r);
      rk_ready = 1'b1;
      start    = 1'b1;
      key_in   = ks[10];
      step();
      start    = 1'b0;
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      t_start  = cyc_cnt;
      check("busy_after_start", busy, 1);
      cyc = 0;
      for (int er = 10; er >= 0; er--) begin
         while (!rk_valid && cyc < 20) begin step(); cyc++; end
         if (!rk_valid) begin
            check("valid_timeout", rk_valid, 1);
            return;
         end
         if (er == 10) check("first_valid_latency", cyc, 0);
         else          check("handshake_gap", cyc, GAP);
         check("rk", rk, ks[er]);
         check("rk_round", rk_round, er);
         if (er == hold_at) begin
            rk_ready = 1'b0;
            for (int i = 0; i < 7; i++) begin
               step();
               check("hold_rk", rk, ks[er]);
               check("hold_round", rk_round, er);
               check("hold_valid", rk_valid, 1);
            end
         end else if (rand_bp) begin
            rk_ready = 1'b0;
            repeat ($urandom_range(0, 3)) step();
            check("bp_rk", rk, ks[er]);
         end
         rk_ready = 1'b1;
         step();                                   // handshake edge
         if (rand_bp) rk_ready = 1'($urandom_range(0, 1));
         cyc = 0;
         if (er == 0) begin
            check("done_high", done, 1);
            check("busy_end", busy, 0);
            check("valid_end", rk_valid, 0);
            if (!rand_bp && hold_at < 0)
               check("start_to_done", cyc_cnt - t_start, 11 + 10*GAP);
            step();
            check("done_one_cycle", done, 0);
         end else begin
            check("valid_low_in_sub", rk_valid, 0);
            check("busy_in_sub", busy, 1);
            if (er == rst_at) begin
               if (GAP > 1) step();
               rst = 1'b1;
               #1;
               check("rst_busy", busy, 0);
               check("rst_valid", rk_valid, 0);
               check("rst_rk", rk, 0);
               check("rst_round", rk_round, 0);
               check("rst_done", done, 0);
               step();
               rst = 1'b0;
               rk_ready = 1'b1;
               begin
                  bit seen;
                  seen = 1'b0;
                  repeat (8) begin
                     step();
                     seen = seen | rk_valid | done;
                  end
                  check("quiet_after_rst", seen, 0);
               end
               return;
            end
            if (poke) begin
               start  = 1'b1;
               key_in = {$urandom, $urandom, $urandom, $urandom};
               step();
               start  = 1'b0;
               cyc    = 1;
               check("busy_during_poke", busy, 1);
            end
         end
      end
   endtask

   initial begin
      logic [127:0] k0;
      build_tables();
      rst      = 1'b1;
      start    = 1'b0;
      rk_ready = 1'b1;
      key_in   = '0;
      step();
      start    = 1'b1;                 // ignored while in reset
      key_in   = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
      step();
      check("reset_busy", busy, 0);
      check("reset_valid", rk_valid, 0);
      check("reset_rk", rk, 0);
      check("reset_round", rk_round, 0);
      check("reset_done", done, 0);
      start = 1'b0;
      rst   = 1'b0;

      k0 = 128'h000102030405060708090a0b0c0d0e0f;
      run_seq(k0, 1'b0, 1'b0, -1, -1);              // round trip + timing
      run_seq(128'h0, 1'b0, 1'b0, -1, -1);          // all-zero key
      run_seq(k0, 1'b0, 1'b0, -1, 5);               // hold at round 5
      run_seq(k0, 1'b0, 1'b1, -1, -1);              // start while busy
      run_seq(k0, 1'b0, 1'b0, 3, -1);               // reset mid-operation
      run_seq(k0, 1'b0, 1'b0, -1, -1);              // restart after reset
      for (int i = 0; i < 4; i++)
         run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/inv_key_expansion.md
INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 Parameter: none; the block is fixed to AES-128, with 10 rounds and RCon table {01,02,04,08,10,20,40,80,1b,36}.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  load request; sampled only in IDLE.
REQ-005 key_in  in  128  round-10 key; word i = bits [32i+31:32i].
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 rk_valid  out  1  round key on rk is valid.
REQ-008 rk_ready  in  1  consumer accepts rk when rk_valid is also high.
REQ-009 rk  out  128  current round key, same word mapping as key_in.
REQ-010 rk_round  out  4  index of rk, 10 down to 0.
REQ-011 done  out  1  one-cycle pulse after round 0 is accepted.

Function
REQ-012 States: IDLE, EMIT, SUB. No other states exist.
REQ-013 IDLE with start=1: capture key_in into the key register, set round=10, go to EMIT. rk_valid rises on the following cycle.
REQ-014 EMIT: rk_valid=1, rk=key register, rk_round=round. rk and rk_round hold stable until the handshake (rk_valid and rk_ready).
REQ-015 EMIT handshake with round=0: go to IDLE and assert done for exactly the next cycle.
REQ-016 EMIT handshake with round>0: go to SUB with byte counter=0.
REQ-017 Previous-key arithmetic, given current words n0..n3:
- w3=n3^n2, w2=n2^n1, w1=n1^n0.
- rot={w3[7:0],w3[31:8]}; Q = AES S-box applied to each byte of rot.
- t={Q[31:8], RCon[round-1]^Q[7:0]}; w0=n0^t.
REQ-018 SUB (serial): substitute one byte per cycle, byte index = counter (0..3), using one shared S-box instance. On the edge where counter=3, write {w3,w2,w1,w0} to the key register, decrement round, and go to EMIT. rk_valid therefore reasserts 4 cycles after the handshake edge.
REQ-019 start while busy is ignored and does not disturb the operation in progress.
REQ-020 rk_valid is low in IDLE and SUB. rk_ready is don't-care outside EMIT.
REQ-021 rk_round never wraps: no decrement occurs below 0.
REQ-022 rk is driven from a register, with no combinational path from key_in or rk_ready to rk.

Reset
REQ-023 While rst=1: state=IDLE; key register, round, and byte counter = 0; rk_valid=0, done=0, busy=0, rk=0, rk_round=0.
REQ-024 Reset asserted mid-operation aborts immediately. No further rk_valid or done occurs until a new start.
REQ-025 After rst deasserts, the first start is accepted on the first rising edge.

Configuration
REQ-026 Macro INV_KEYEXP_PARALLEL_SBOX_EN.
- Defined: four S-box instances; SUB lasts exactly one cycle; rk_valid reasserts 1 cycle after the handshake edge.
- Undefined: byte-serial SUB of REQ-018.
- Arithmetic results are identical in both builds.

Verification
REQ-027 Round-trip test:
- Stimulus: take k0=000102030405060708090a0b0c0d0e0f; chain the team's forward key-expansion block with COUNTER 0..9 to get k1..k10; start with key_in=k10 and hold rk_ready=1.
- Required: 11 accepted keys equal k10..k0 in order, with rk_round 10..0, then done=1 for one cycle.
REQ-028 All-zero key:
- Stimulus: key_in = the forward-expanded k10 of key 0.
- Required: final rk=0 with rk_round=0, which checks RCon[0]=01 on the 1->0 step.
REQ-029 Backpressure:
- Stimulus: hold rk_ready=0 for 7 cycles at round 5.
- Required: rk, rk_round=5, and rk_valid stay constant; the sequence resumes unchanged when rk_ready goes high.
REQ-030 Start while busy:
- Stimulus: pulse start with a different key_in during SUB.
- Required: the output sequence is unaffected and busy stays 1.
REQ-031 Reset mid-operation:
- Stimulus: assert rst at round 3 during SUB.
- Required: busy=0, rk_valid=0, rk=0 in the same cycle; a restart with k10 reproduces the full sequence.
REQ-032 Timing:
- Serial build: handshake-to-next-rk_valid is 4 cycles; total start-to-done is 11 + 40 cycles with rk_ready=1.
- Parallel build: the same gaps are 1 cycle; total start-to-done is 11 + 10 cycles.
